p0011: RTL and testbench
========================

Name: p0011

Overview:
Self-running solver for Project Euler problem 11. It finds the greatest product of four adjacent numbers in the same direction (right, down, diagonal down-right, diagonal down-left) in the fixed 20x20 problem grid. It has no data inputs: after reset it scans an internal grid ROM and publishes the 32-bit maximum on result, then asserts done. It sits alongside the other pNNNN solver blocks and is observed only through result, done and error.

Parameters:
GRID_N, 20, grid side length (rows = columns).
RUN_LEN, 4, number of adjacent values per product.
MAX_CYCLES, 4096, watchdog limit in clock cycles from reset release to done.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  synchronous active-high reset; restarts the scan.
result  output  32  running maximum product; final answer while done=1.
done  output  1  high once the scan has finished; sticky until rst.
error  output  1  high on watchdog expiry or internal fault; sticky until rst.

Behaviour:
- Reset (rst=1 at clk edge): result=0, done=0, error=0, scan indices (row=0, col=0, dir=RIGHT) and pipeline valids cleared. Scan starts on the first edge with rst=0.
- Grid: 400 entries, 7-bit unsigned (00..99), row-major, address = row*20+col, held in a ROM with four asynchronous read ports.
- Scan FSM states: IDLE (one cycle after reset), SCAN, DRAIN, DONE, ERR.
- SCAN issues one candidate per cycle in order dir (RIGHT, DOWN, DIAG_DR, DIAG_DL) within col within row.
- Candidate in bounds: RIGHT needs col<=16; DOWN needs row<=16; DIAG_DR needs row<=16 and col<=16; DIAG_DL needs row<=16 and col>=3.
- Out-of-bounds candidates are issued with valid=0 and skipped by the comparator, so the scan length is a fixed 1600 cycles.
- Pipeline: stage 1 reads the 4 ROM values; stage 2 forms two 14-bit pair products; stage 3 forms the 28-bit full product, zero-extended to 32 bits.
- Stage 3 compares the product and loads result when valid and the product is strictly greater than result. Ties keep the old value.
- After the last candidate (row 19, col 19, DIAG_DL) is issued, the FSM enters DRAIN for 3 cycles, then DONE. done rises on the DONE entry edge. result is final on or before that edge and never changes afterwards.
- DONE and ERR are absorbing; only rst leaves them.
- error=1 (ERR state, done stays 0) in either case:
  - the cycle counter reaches MAX_CYCLES before DONE;
  - the FSM is in an illegal state encoding.
- Nominal completion: about 1605 cycles after reset release.
- Width rule: 99^4 = 96059601 < 2^27, so no overflow is possible; no saturation logic.
- Reset mid-scan: all state is discarded and the scan restarts from row 0, col 0.

Decomposition:
- Package p0011_pkg:
  - GRID_N, RUN_LEN;
  - direction enum (RIGHT, DOWN, DIAG_DR, DIAG_DL);
  - FSM state enum;
  - expected answer constant 70600674 for benches.
- One sub-module: p0011_grid_rom (400x7 constant table, four combinational read ports, address width 9).

Test Plan:
- Reset 2 cycles, release, run -> done=1 within 1610 cycles; result=70600674 (0x043547E2); error=0.
- After done, hold 200 cycles -> result, done and error unchanged.
- Assert rst at cycle 800 for 1 cycle -> next cycle result=0, done=0; rerun ends with result=70600674.
- ROM spot check on p0011_grid_rom:
  - addr 0 -> 8; addr 3 -> 97; addr 399 -> 48;
  - addr 12*20+6 -> 89 (winning DIAG_DL run 89, 94, 97, 87).
- Instance with MAX_CYCLES=100 -> error=1 at cycle 100; done stays 0; result frozen.
- Hold rst=1 for 50 cycles -> result=0, done=0 and error=0 throughout.

Source files
------------

// File: rtl/p0011_pkg.sv
// p0011_pkg: shared definitions for the Project Euler #11 solver.
//   GRID_N / RUN_LEN  grid side and number of adjacent cells per product
//   dir_e             scan direction of one candidate run
//   state_e           scan FSM states (3-bit, so illegal encodings exist)
//   P0011_ANSWER      known greatest product, for benches
package p0011_pkg;

    localparam int unsigned GRID_N   = 20;
    localparam int unsigned RUN_LEN  = 4;
    localparam int unsigned CELLS    = GRID_N * GRID_N;
    localparam int unsigned IDX_W    = $clog2(GRID_N);
    localparam int unsigned ADDR_W   = $clog2(CELLS);
    localparam int unsigned VAL_W    = 7;
    localparam int unsigned PAIR_W   = 2 * VAL_W;
    localparam int unsigned PROD_W   = 4 * VAL_W;
    localparam int unsigned RESULT_W = 32;

    localparam logic [RESULT_W-1:0] P0011_ANSWER = 32'd70600674;

    typedef enum logic [1:0] {
        RIGHT   = 2'd0,
        DOWN    = 2'd1,
        DIAG_DR = 2'd2,
        DIAG_DL = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/p0011_if.sv
// p0011_if: observation bus of the solver.
//   result  32-bit running maximum, final answer while done=1
//   done    scan finished (sticky until reset)
//   error   watchdog expiry or illegal FSM state (sticky until reset)
// master = solver side (drives), slave = observer side.
interface p0011_if;
    import p0011_pkg::*;

    logic [RESULT_W-1:0] result;
    logic                done;
    logic                error;

    modport master (output result, done, error);
    modport slave  (input  result, done, error);

endinterface

// File: rtl/p0011_grid_rom.sv
// p0011_grid_rom: constant 20x20 problem grid, row-major (addr = row*20+col),
// values 00..99 in 7 bits.
//   addr_i  RUN_LEN packed read addresses (9 bits each)
//   data_o  RUN_LEN combinational read data; addresses past the grid read 0
module p0011_grid_rom
    import p0011_pkg::*;
(
    input  logic [RUN_LEN-1:0][ADDR_W-1:0] addr_i,
    output logic [RUN_LEN-1:0][VAL_W-1:0]  data_o
);

    localparam logic [ADDR_W-1:0] CELL_END = ADDR_W'(CELLS);

    localparam logic [VAL_W-1:0] GRID [CELLS] = '{
        7'd08, 7'd02, 7'd22, 7'd97, 7'd38, 7'd15, 7'd00, 7'd40, 7'd00, 7'd75, 7'd04, 7'd05, 7'd07, 7'd78, 7'd52, 7'd12, 7'd50, 7'd77, 7'd91, 7'd08,
        7'd49, 7'd49, 7'd99, 7'd40, 7'd17, 7'd81, 7'd18, 7'd57, 7'd60, 7'd87, 7'd17, 7'd40, 7'd98, 7'd43, 7'd69, 7'd48, 7'd04, 7'd56, 7'd62, 7'd00,
        7'd81, 7'd49, 7'd31, 7'd73, 7'd55, 7'd79, 7'd14, 7'd29, 7'd93, 7'd71, 7'd40, 7'd67, 7'd53, 7'd88, 7'd30, 7'd03, 7'd49, 7'd13, 7'd36, 7'd65,
        7'd52, 7'd70, 7'd95, 7'd23, 7'd04, 7'd60, 7'd11, 7'd42, 7'd69, 7'd24, 7'd68, 7'd56, 7'd01, 7'd32, 7'd56, 7'd71, 7'd37, 7'd02, 7'd36, 7'd91,
        7'd22, 7'd31, 7'd16, 7'd71, 7'd51, 7'd67, 7'd63, 7'd89, 7'd41, 7'd92, 7'd36, 7'd54, 7'd22, 7'd40, 7'd40, 7'd28, 7'd66, 7'd33, 7'd13, 7'd80,
        7'd24, 7'd47, 7'd32, 7'd60, 7'd99, 7'd03, 7'd45, 7'd02, 7'd44, 7'd75, 7'd33, 7'd53, 7'd78, 7'd36, 7'd84, 7'd20, 7'd35, 7'd17, 7'd12, 7'd50,
        7'd32, 7'd98, 7'd81, 7'd28, 7'd64, 7'd23, 7'd67, 7'd10, 7'd26, 7'd38, 7'd40, 7'd67, 7'd59, 7'd54, 7'd70, 7'd66, 7'd18, 7'd38, 7'd64, 7'd70,
        7'd67, 7'd26, 7'd20, 7'd68, 7'd02, 7'd62, 7'd12, 7'd20, 7'd95, 7'd63, 7'd94, 7'd39, 7'd63, 7'd08, 7'd40, 7'd91, 7'd66, 7'd49, 7'd94, 7'd21,
        7'd24, 7'd55, 7'd58, 7'd05, 7'd66, 7'd73, 7'd99, 7'd26, 7'd97, 7'd17, 7'd78, 7'd78, 7'd96, 7'd83, 7'd14, 7'd88, 7'd34, 7'd89, 7'd63, 7'd72,
        7'd21, 7'd36, 7'd23, 7'd09, 7'd75, 7'd00, 7'd76, 7'd44, 7'd20, 7'd45, 7'd35, 7'd14, 7'd00, 7'd61, 7'd33, 7'd97, 7'd34, 7'd31, 7'd33, 7'd95,
        7'd78, 7'd17, 7'd53, 7'd28, 7'd22, 7'd75, 7'd31, 7'd67, 7'd15, 7'd94, 7'd03, 7'd80, 7'd04, 7'd62, 7'd16, 7'd14, 7'd09, 7'd53, 7'd56, 7'd92,
        7'd16, 7'd39, 7'd05, 7'd42, 7'd96, 7'd35, 7'd31, 7'd47, 7'd55, 7'd58, 7'd88, 7'd24, 7'd00, 7'd17, 7'd54, 7'd24, 7'd36, 7'd29, 7'd85, 7'd57,
        7'd86, 7'd56, 7'd00, 7'd48, 7'd35, 7'd71, 7'd89, 7'd07, 7'd05, 7'd44, 7'd44, 7'd37, 7'd44, 7'd60, 7'd21, 7'd58, 7'd51, 7'd54, 7'd17, 7'd58,
        7'd19, 7'd80, 7'd81, 7'd68, 7'd05, 7'd94, 7'd47, 7'd69, 7'd28, 7'd73, 7'd92, 7'd13, 7'd86, 7'd52, 7'd17, 7'd77, 7'd04, 7'd89, 7'd55, 7'd40,
        7'd04, 7'd52, 7'd08, 7'd83, 7'd97, 7'd35, 7'd99, 7'd16, 7'd07, 7'd97, 7'd57, 7'd32, 7'd16, 7'd26, 7'd26, 7'd79, 7'd33, 7'd27, 7'd98, 7'd66,
        7'd88, 7'd36, 7'd68, 7'd87, 7'd57, 7'd62, 7'd20, 7'd72, 7'd03, 7'd46, 7'd33, 7'd67, 7'd46, 7'd55, 7'd12, 7'd32, 7'd63, 7'd93, 7'd53, 7'd69,
        7'd04, 7'd42, 7'd16, 7'd73, 7'd38, 7'd25, 7'd39, 7'd11, 7'd24, 7'd94, 7'd72, 7'd18, 7'd08, 7'd46, 7'd29, 7'd32, 7'd40, 7'd62, 7'd76, 7'd36,
        7'd20, 7'd69, 7'd36, 7'd41, 7'd72, 7'd30, 7'd23, 7'd88, 7'd34, 7'd62, 7'd99, 7'd69, 7'd82, 7'd67, 7'd59, 7'd85, 7'd74, 7'd04, 7'd36, 7'd16,
        7'd20, 7'd73, 7'd35, 7'd29, 7'd78, 7'd31, 7'd90, 7'd01, 7'd74, 7'd31, 7'd49, 7'd71, 7'd48, 7'd86, 7'd81, 7'd16, 7'd23, 7'd57, 7'd05, 7'd54,
        7'd01, 7'd70, 7'd54, 7'd71, 7'd83, 7'd51, 7'd54, 7'd69, 7'd16, 7'd92, 7'd33, 7'd48, 7'd61, 7'd43, 7'd52, 7'd01, 7'd89, 7'd19, 7'd67, 7'd48
    };

    for (genvar k = 0; k < RUN_LEN; k++) begin : g_port
        assign data_o[k] = (addr_i[k] < CELL_END) ? GRID[addr_i[k]] : '0;
    end

endmodule

// File: rtl/p0011.sv
// p0011: self-running Project Euler #11 solver. Scans every (row, col, dir)
// candidate of the grid ROM, one per cycle, through a 3-stage product
// pipeline and keeps the greatest product of RUN_LEN adjacent cells.
//   clk  system clock
//   rst  synchronous active-high reset, restarts the scan
//   bus  p0011_if.master: result (running max), done, error (both sticky)
// MAX_CYCLES: watchdog limit in cycles from reset release to done.
module p0011
    import p0011_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 4096
) (
    input  logic    clk,
    input  logic    rst,
    p0011_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(GRID_N - 1);
    localparam logic [IDX_W-1:0] LAST_START = IDX_W'(GRID_N - RUN_LEN);
    localparam logic [IDX_W-1:0] FIRST_DL   = IDX_W'(RUN_LEN - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'd2;
    localparam logic [31:0]      WD_LAST    = 32'(MAX_CYCLES - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    row_q;
    logic [IDX_W-1:0]    col_q;
    dir_e                dir_q;
    logic [1:0]          drain_q;
    logic [31:0]         cyc_q;
    logic                done_q;
    logic                error_q;
    logic [RESULT_W-1:0] result_q;

    logic                           s1_v_q;
    logic [RUN_LEN-1:0][VAL_W-1:0]  s1_val_q;
    logic                           s2_v_q;
    logic [PAIR_W-1:0]              pair_lo_d, pair_hi_d;
    logic [PAIR_W-1:0]              pair_lo_q, pair_hi_q;
    logic [PROD_W-1:0]              prod_d;

    logic [ADDR_W-1:0]              base_addr;
    logic [ADDR_W-1:0]              stride;
    logic [RUN_LEN-1:0][ADDR_W-1:0] rd_addr;
    logic [RUN_LEN-1:0][VAL_W-1:0]  rd_data;
    logic                           in_bounds;
    logic                           issue_valid;
    logic                           last_cand;
    logic                           running;
    logic                           wd_hit;
    logic                           drain_exit;
    logic                           upd_en;

    // Candidate address generation: cell k of the run sits k strides from
    // the start cell. Out-of-grid runs still issue (valid=0) so the scan
    // length does not depend on the grid contents.
    always_comb begin
        stride    = '0;
        in_bounds = 1'b0;
        base_addr = ADDR_W'(row_q) * ADDR_W'(GRID_N) + ADDR_W'(col_q);
        case (dir_q)
            RIGHT: begin
                stride    = ADDR_W'(1);
                in_bounds = (col_q <= LAST_START);
            end
            DOWN: begin
                stride    = ADDR_W'(GRID_N);
                in_bounds = (row_q <= LAST_START);
            end
            DIAG_DR: begin
                stride    = ADDR_W'(GRID_N + 1);
                in_bounds = (row_q <= LAST_START) && (col_q <= LAST_START);
            end
            DIAG_DL: begin
                stride    = ADDR_W'(GRID_N - 1);
                in_bounds = (row_q <= LAST_START) && (col_q >= FIRST_DL);
            end
            default: begin
                stride    = '0;
                in_bounds = 1'b0;
            end
        endcase
        for (int unsigned k = 0; k < RUN_LEN; k++) begin
            rd_addr[k] = base_addr + stride * ADDR_W'(k);
        end
        issue_valid = (state_q == SCAN) && in_bounds;
        last_cand   = (row_q == LAST_IDX) && (col_q == LAST_IDX) && (dir_q == DIAG_DL);
    end

    p0011_grid_rom u_rom (
        .addr_i (rd_addr),
        .data_o (rd_data)
    );

    assign running    = (state_q == IDLE) || (state_q == SCAN) || (state_q == DRAIN);
    assign wd_hit     = (cyc_q == WD_LAST);
    assign drain_exit = (state_q == DRAIN) && (drain_q == DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            dir_q   <= RIGHT;
            drain_q <= '0;
            cyc_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (running) begin
                cyc_q <= cyc_q + 32'd1;
            end
            case (state_q)
                IDLE: state_q <= SCAN;
                SCAN: begin
                    if (last_cand) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end else if (dir_q == DIAG_DL) begin
                        dir_q <= RIGHT;
                        if (col_q == LAST_IDX) begin
                            col_q <= '0;
                            row_q <= row_q + IDX_W'(1);
                        end else begin
                            col_q <= col_q + IDX_W'(1);
                        end
                    end else begin
                        dir_q <= dir_e'(dir_q + 2'd1);
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                DONE: state_q <= DONE;
                ERR:  state_q <= ERR;
                default: begin
                    state_q <= ERR;
                    error_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
            // Watchdog overrides the case above; completing on the same
            // edge counts as finishing in time.
            if (running && wd_hit && !drain_exit) begin
                state_q <= ERR;
                error_q <= 1'b1;
                done_q  <= 1'b0;
            end
        end
    end

    assign pair_lo_d = PAIR_W'(s1_val_q[0]) * PAIR_W'(s1_val_q[1]);
    assign pair_hi_d = PAIR_W'(s1_val_q[2]) * PAIR_W'(s1_val_q[3]);
    assign prod_d    = PROD_W'(pair_lo_q) * PROD_W'(pair_hi_q);

    // Strictly greater keeps the earlier value on ties; updates are only
    // accepted while scanning/draining so result freezes in DONE and ERR.
    assign upd_en = s2_v_q && ((state_q == SCAN) || (state_q == DRAIN))
                    && (RESULT_W'(prod_d) > result_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_val_q  <= '0;
            s2_v_q    <= 1'b0;
            pair_lo_q <= '0;
            pair_hi_q <= '0;
            result_q  <= '0;
        end else begin
            s1_v_q    <= issue_valid;
            s1_val_q  <= rd_data;
            s2_v_q    <= s1_v_q;
            pair_lo_q <= pair_lo_d;
            pair_hi_q <= pair_hi_d;
            if (upd_en) begin
                result_q <= RESULT_W'(prod_d);
            end
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_p0011.sv
// tb_p0011: self-checking bench for the p0011 solver, its grid ROM and a
// short-watchdog instance.
module tb_p0011;
    import p0011_pkg::*;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic rst_wd = 1'b1;
    logic [RUN_LEN-1:0][ADDR_W-1:0] rom_addr = '0;
    logic [RUN_LEN-1:0][VAL_W-1:0]  rom_data;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q [$];

    p0011_if bus_main ();
    p0011_if bus_wd ();

    p0011 #(.MAX_CYCLES(4096)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_main)
    );

    p0011 #(.MAX_CYCLES(100)) dut_wd (
        .clk (clk),
        .rst (rst_wd),
        .bus (bus_wd)
    );

    p0011_grid_rom u_rom_chk (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_main.result !== 32'd0) begin
            errors++; $display("FAIL reset_result: got %0d, want 0", bus_main.result);
        end
        checks++;
        if (bus_main.done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b, want 0", bus_main.done);
        end
        checks++;
        if (bus_main.error !== 1'b0) begin
            errors++; $display("FAIL reset_error: got %b, want 0", bus_main.error);
        end
    endtask

    task automatic test_full_run();
        int unsigned n = 0;
        logic [31:0] want;
        exp_q.push_back(P0011_ANSWER);
        rst = 1'b0;
        while (bus_main.done !== 1'b1 && n < 1610) begin
            @(negedge clk);
            n++;
        end
        want = exp_q.pop_front();
        checks++;
        if (bus_main.done !== 1'b1) begin
            errors++; $display("FAIL run_done: got %b after %0d cycles, want 1", bus_main.done, n);
        end
        checks++;
        if (n != 1604) begin
            errors++; $display("FAIL run_latency: done after %0d cycles, want 1604", n);
        end
        checks++;
        if (bus_main.result !== want) begin
            errors++; $display("FAIL run_result: got %0d, want %0d", bus_main.result, want);
        end
        checks++;
        if (bus_main.error !== 1'b0) begin
            errors++; $display("FAIL run_error: got %b, want 0", bus_main.error);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checks++;
            if (bus_main.result !== P0011_ANSWER || bus_main.done !== 1'b1 || bus_main.error !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d: result=%0d done=%b error=%b, want %0d/1/0",
                         i, bus_main.result, bus_main.done, bus_main.error, P0011_ANSWER);
            end
        end
    endtask

    task automatic test_long_reset();
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (bus_main.result !== 32'd0 || bus_main.done !== 1'b0 || bus_main.error !== 1'b0) begin
                errors++;
                $display("FAIL long_reset_cycle_%0d: result=%0d done=%b error=%b, want 0/0/0",
                         i, bus_main.result, bus_main.done, bus_main.error);
            end
        end
    endtask

    task automatic test_mid_reset();
        int unsigned n = 0;
        logic [31:0] want;
        rst = 1'b0;
        repeat (800) @(negedge clk);
        checks++;
        if (bus_main.done !== 1'b0) begin
            errors++; $display("FAIL mid_not_done: got done=%b at cycle 800, want 0", bus_main.done);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_main.result !== 32'd0 || bus_main.done !== 1'b0 || bus_main.error !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: result=%0d done=%b error=%b, want 0/0/0",
                     bus_main.result, bus_main.done, bus_main.error);
        end
        exp_q.push_back(P0011_ANSWER);
        rst = 1'b0;
        while (bus_main.done !== 1'b1 && n < 1610) begin
            @(negedge clk);
            n++;
        end
        want = exp_q.pop_front();
        checks++;
        if (bus_main.done !== 1'b1 || n != 1604) begin
            errors++; $display("FAIL rerun_done: done=%b after %0d cycles, want 1 after 1604", bus_main.done, n);
        end
        checks++;
        if (bus_main.result !== want) begin
            errors++; $display("FAIL rerun_result: got %0d, want %0d", bus_main.result, want);
        end
    endtask

    task automatic test_rom();
        int unsigned a_tab [8] = '{0, 3, 399, 246, 265, 284, 303, 19};
        int unsigned v_tab [8] = '{8, 97, 48, 89, 94, 97, 87, 8};
        logic [31:0] want;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                rom_addr[k] = ADDR_W'(a_tab[r*4+k]);
                exp_q.push_back(32'(v_tab[r*4+k]));
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                want = exp_q.pop_front();
                checks++;
                if (32'(rom_data[k]) !== want) begin
                    errors++;
                    $display("FAIL rom_addr_%0d: got %0d, want %0d", a_tab[r*4+k], rom_data[k], want);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        logic [31:0] frozen;
        rst_wd = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_wd.error !== 1'b0 || bus_wd.done !== 1'b0 || bus_wd.result !== 32'd0) begin
            errors++;
            $display("FAIL wd_reset: result=%0d done=%b error=%b, want 0/0/0",
                     bus_wd.result, bus_wd.done, bus_wd.error);
        end
        rst_wd = 1'b0;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            checks++;
            if (bus_wd.error !== 1'b0 || bus_wd.done !== 1'b0) begin
                errors++;
                $display("FAIL wd_early_cycle_%0d: error=%b done=%b, want 0/0", n, bus_wd.error, bus_wd.done);
            end
        end
        @(negedge clk);
        checks++;
        if (bus_wd.error !== 1'b1) begin
            errors++; $display("FAIL wd_error_at_100: got %b, want 1", bus_wd.error);
        end
        checks++;
        if (bus_wd.done !== 1'b0) begin
            errors++; $display("FAIL wd_done_at_100: got %b, want 0", bus_wd.done);
        end
        frozen = bus_wd.result;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (bus_wd.result !== frozen || bus_wd.error !== 1'b1 || bus_wd.done !== 1'b0) begin
                errors++;
                $display("FAIL wd_frozen_cycle_%0d: result=%0d error=%b done=%b, want %0d/1/0",
                         i, bus_wd.result, bus_wd.error, bus_wd.done, frozen);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_hold();
        test_long_reset();
        test_mid_reset();
        test_rom();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
